// File: rtl/cell_stream_fetch.sv
// rtl/cell_stream_fetch.sv - raster-order cell fetcher from Cell Cache to HOG with credit-gated 2-entry output FIFO
module cell_stream_fetch #(
    parameter int  CELL_WIDTH   = 768,
    parameter int  MAX_ROW_CNUM = 30,
    parameter int  MAX_COL_CNUM = 40,
    localparam int CELL_ADDR_W  = $clog2(MAX_ROW_CNUM*MAX_COL_CNUM),
    localparam int ROW_ADDR_W   = $clog2(MAX_ROW_CNUM+1),
    localparam int COL_ADDR_W   = $clog2(MAX_COL_CNUM+1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cell_fetch_start_i,
    input  logic [ROW_ADDR_W-1:0]  cfg_row_num_i,
    input  logic [COL_ADDR_W-1:0]  cfg_col_num_i,
    input  logic [CELL_WIDTH-1:0]  bwd_cell_data_i,
    output logic                   bwd_cell_en_o,
    output logic [CELL_ADDR_W-1:0] bwd_cell_addr_o,
    output logic [CELL_WIDTH-1:0]  fwd_cell_data_o,
    output logic [3:0]             fwd_cell_edge_o,
    output logic                   fwd_cell_last_o,
    output logic                   fwd_cell_valid_o,
    input  logic                   fwd_cell_ready_i,
    output logic                   busy_o,
    output logic                   frame_done_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ROW_ADDR_W-1:0]  ROW_MAX  = ROW_ADDR_W'(MAX_ROW_CNUM);
    localparam logic [COL_ADDR_W-1:0]  COL_MAX  = COL_ADDR_W'(MAX_COL_CNUM);
    localparam logic [ROW_ADDR_W-1:0]  ROW_ONE  = ROW_ADDR_W'(1);
    localparam logic [COL_ADDR_W-1:0]  COL_ONE  = COL_ADDR_W'(1);
    localparam logic [CELL_ADDR_W-1:0] ADDR_ONE = CELL_ADDR_W'(1);

    logic [1:0]             state_q, state_d;
    logic [ROW_ADDR_W-1:0]  row_q, rows_m1_q, rows_eff;
    logic [COL_ADDR_W-1:0]  col_q, cols_m1_q, cols_eff;
    logic [CELL_ADDR_W-1:0] addr_q;
    logic                   inflight_q;
    logic [4:0]             tag_q, tag_d;
    logic                   done_q;

    logic [CELL_WIDTH-1:0]  data_mem_q [2];
    logic [4:0]             tag_mem_q  [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             count_q;

    logic       start_acc, fifo_valid, pop, push, issue, last_issue, head_last;
    logic       row_first, row_final, col_first, col_final;
    logic [2:0] credit;

    assign start_acc  = cell_fetch_start_i && (state_q == ST_IDLE);
    assign fifo_valid = (count_q != 2'd0);
    assign pop        = fifo_valid && fwd_cell_ready_i;
    assign push       = inflight_q;
    assign head_last  = tag_mem_q[rd_ptr_q][0];

    // Slots already committed: stored cells plus the RAM return still in flight, minus the one leaving now.
    assign credit     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (state_q == ST_RUN) && (credit < 3'd2);

    assign row_first  = (row_q == '0);
    assign row_final  = (row_q == rows_m1_q);
    assign col_first  = (col_q == '0);
    assign col_final  = (col_q == cols_m1_q);
    assign last_issue = issue && row_final && col_final;
    assign tag_d      = {row_first, row_final, col_first, col_final, row_final && col_final};

    always_comb begin
        rows_eff = cfg_row_num_i;
        if (cfg_row_num_i == '0 || cfg_row_num_i > ROW_MAX) rows_eff = ROW_MAX;
        cols_eff = cfg_col_num_i;
        if (cfg_col_num_i == '0 || cfg_col_num_i > COL_MAX) cols_eff = COL_MAX;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_acc) state_d = ST_RUN;
            ST_RUN:   if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (pop && head_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            rows_m1_q  <= '0;
            cols_m1_q  <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            tag_q      <= tag_d;
            done_q     <= (state_q == ST_DRAIN) && pop && head_last;
            if (start_acc) begin
                row_q     <= '0;
                col_q     <= '0;
                addr_q    <= '0;
                rows_m1_q <= rows_eff - ROW_ONE;
                cols_m1_q <= cols_eff - COL_ONE;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_ONE;
                if (col_final) begin
                    col_q <= '0;
                    row_q <= row_q + ROW_ONE;
                end else begin
                    col_q <= col_q + COL_ONE;
                end
            end
        end
    end

    // Returning RAM word and its registered tag land together in the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                data_mem_q[i] <= '0;
                tag_mem_q[i]  <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                data_mem_q[wr_ptr_q] <= bwd_cell_data_i;
                tag_mem_q[wr_ptr_q]  <= tag_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == 2'd2) && !pop));

    assign bwd_cell_en_o    = issue;
    assign bwd_cell_addr_o  = addr_q;
    assign fwd_cell_data_o  = data_mem_q[rd_ptr_q];
    assign fwd_cell_edge_o  = tag_mem_q[rd_ptr_q][4:1];
    assign fwd_cell_last_o  = head_last;
    assign fwd_cell_valid_o = fifo_valid;
    assign busy_o           = (state_q != ST_IDLE);
    assign frame_done_o     = done_q;

endmodule

// File: tb/tb_cell_stream_fetch.sv
// tb/tb_cell_stream_fetch.sv - directed self-checking bench for cell_stream_fetch
module tb_cell_stream_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [4:0]   cfg_row;
    logic [5:0]   cfg_col;
    logic [767:0] ram_q;
    logic         en;
    logic [10:0]  addr;
    logic [767:0] data;
    logic [3:0]   edge_f;
    logic         last;
    logic         valid;
    logic         ready;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] first_edge, final_edge;
    logic       final_last;

    always #5 clk = ~clk;

    cell_stream_fetch dut (
        .clk                (clk),
        .rst                (rst),
        .cell_fetch_start_i (start),
        .cfg_row_num_i      (cfg_row),
        .cfg_col_num_i      (cfg_col),
        .bwd_cell_data_i    (ram_q),
        .bwd_cell_en_o      (en),
        .bwd_cell_addr_o    (addr),
        .fwd_cell_data_o    (data),
        .fwd_cell_edge_o    (edge_f),
        .fwd_cell_last_o    (last),
        .fwd_cell_valid_o   (valid),
        .fwd_cell_ready_i   (ready),
        .busy_o             (busy),
        .frame_done_o       (done)
    );

    function automatic logic [767:0] cell_of(input int idx);
        logic [767:0] v;
        v = '0;
        for (int i = 0; i < 24; i++) v[i*32 +: 32] = {8'hC3, 8'(i), 16'(idx)};
        return v;
    endfunction

    // Cell Cache model: one-cycle read latency.
    always @(posedge clk) if (en) ram_q <= cell_of(int'(addr));

    task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input int r, input int c);
        @(negedge clk);
        cfg_row = 5'(r);
        cfg_col = 6'(c);
        start   = 1'b1;
        ready   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on", busy, 1'b1);
    endtask

    // mode 0: ready high; 1: random ready; 2: stall evt_len cycles at cell evt; 3: extra start at cell evt
    task automatic run_frame(input int rows, input int cols, input int mode,
                             input int evt, input int evt_len, input int stop_at);
        int total = rows * cols;
        int got = 0, issued = 0, k = 0, fv = -1, gaps = 0, stall = 0;
        bit pulsed = 1'b0;
        logic [767:0] hold_d;
        logic [4:0]   hold_t;
        logic [3:0]   exp_edge;
        int r, c;
        hold_d = '0;
        hold_t = '0;
        while (got < stop_at && k < total * 4 + 64) begin
            start = 1'b0;
            if (mode == 3 && got == evt && !pulsed) begin
                start   = 1'b1;
                cfg_row = 5'd2;
                cfg_col = 6'd2;
                pulsed  = 1'b1;
            end
            if (mode == 1) ready = 1'($urandom_range(0, 1));
            else if (mode == 2 && got == evt && stall < evt_len) ready = 1'b0;
            else ready = 1'b1;
            #1;
            if (en) begin
                chk("addr", addr, issued);
                issued++;
            end
            if (mode == 2 && !ready) begin
                if (stall == 0) begin
                    hold_d = data;
                    hold_t = {edge_f, last};
                end else begin
                    chk("stall_en", en, 1'b0);
                    chk("stall_data", data, hold_d);
                    chk("stall_tag", {edge_f, last}, hold_t);
                end
                if (stall == evt_len - 1) begin
                    chk("stall_occ", issued - got, 2);
                    chk("stall_valid", valid, 1'b1);
                end
                stall++;
            end
            if (valid && ready) begin
                r = got / cols;
                c = got % cols;
                exp_edge = {r == 0, r == rows - 1, c == 0, c == cols - 1};
                chk("data", data, cell_of(got));
                chk("edge", edge_f, exp_edge);
                chk("last", last, got == total - 1);
                if (got == 0) first_edge = edge_f;
                if (got == total - 1) begin
                    final_edge = edge_f;
                    final_last = last;
                end
                got++;
            end else if (mode == 0 && fv >= 0 && !valid) begin
                gaps++;
            end
            if (fv < 0 && valid) fv = k;
            @(negedge clk);
            k++;
        end
        chk("cells", got, stop_at);
        if (stop_at == total) begin
            chk("done_pulse", done, 1'b1);
            chk("busy_off", busy, 1'b0);
            chk("issued", issued, total);
            if (mode == 0) begin
                chk("latency", fv, 2);
                chk("gaps", gaps, 0);
            end
            @(negedge clk);
            chk("done_single", done, 1'b0);
            chk("valid_idle", valid, 1'b0);
            chk("en_idle", en, 1'b0);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_en"}, en, 1'b0);
        chk({tag, "_addr"}, addr, 11'd0);
        chk({tag, "_valid"}, valid, 1'b0);
        chk({tag, "_data"}, data, 768'd0);
        chk({tag, "_edge"}, edge_f, 4'd0);
        chk({tag, "_last"}, last, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        cfg_row = 5'd0;
        cfg_col = 6'd0;
        ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;

        // full default frame, ready held high
        start_frame(30, 40);
        run_frame(30, 40, 0, 0, 0, 1200);
        chk("t1_final_last", final_last, 1'b1);

        // 3x4 with random back-pressure
        start_frame(3, 4);
        run_frame(3, 4, 1, 0, 0, 12);
        chk("t2_edge0", first_edge, 4'b1010);
        chk("t2_edge11", final_edge, 4'b0101);

        // 20-cycle stall mid-frame
        start_frame(30, 40);
        run_frame(30, 40, 2, 300, 20, 1200);

        // 1x1 frame, rows=0 clamp, cols above max clamp
        start_frame(1, 1);
        run_frame(1, 1, 0, 0, 0, 1);
        chk("t4_edge1x1", final_edge, 4'b1111);
        chk("t4_last1x1", final_last, 1'b1);
        start_frame(0, 4);
        run_frame(30, 4, 0, 0, 0, 120);
        start_frame(2, 63);
        run_frame(2, 40, 0, 0, 0, 80);

        // start pulsed while busy is ignored
        start_frame(30, 40);
        run_frame(30, 40, 3, 100, 0, 1200);

        // reset mid-frame, then a fresh frame
        start_frame(30, 40);
        run_frame(30, 40, 0, 0, 0, 500);
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("midrst");
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("postrst");
        start_frame(3, 4);
        run_frame(3, 4, 0, 0, 0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
